// File: rtl/stump_control_fsm.sv
// Stump processor sequencer: FETCH/EXECUTE/MEMORY state register plus a
// combinational decode of the instruction register into datapath controls.
module stump_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    input  logic        mem_ready,
    output logic [1:0]  state,
    output logic        ir_en,
    output logic        pc_en,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic        addr_sel,
    output logic        addr_en,
    output logic        reg_write,
    output logic        wb_sel,
    output logic [2:0]  dest,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic        opB_sel,
    output logic [2:0]  alu_func,
    output logic [1:0]  shift_op,
    output logic        cc_en
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXECUTE = 2'b01,
        S_MEMORY  = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;

    state_t state_q;
    state_t state_d;
    state_t cur;

    logic [2:0] op;
    logic       itype;
    logic       ls_bit;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [1:0] shf;
    logic [3:0] cond;

    assign op     = ir[15:13];
    assign itype  = ir[12];
    assign ls_bit = ir[11];
    assign rd     = ir[10:8];
    assign rs1    = ir[7:5];
    assign rs2    = ir[4:2];
    assign shf    = ir[1:0];
    assign cond   = ir[11:8];

    // Branch condition evaluation against {N,Z,V,C}.
    function automatic logic branch_taken(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        logic t;
        n  = f[3];
        z  = f[2];
        v  = f[1];
        cy = f[0];
        case (c)
            4'd0:    t = 1'b1;
            4'd1:    t = 1'b0;
            4'd2:    t = ~cy & ~z;
            4'd3:    t = cy | z;
            4'd4:    t = ~cy;
            4'd5:    t = cy;
            4'd6:    t = ~z;
            4'd7:    t = z;
            4'd8:    t = ~v;
            4'd9:    t = v;
            4'd10:   t = ~n;
            4'd11:   t = n;
            4'd12:   t = (n == v);
            4'd13:   t = (n != v);
            4'd14:   t = ~z & (n == v);
            default: t = z | (n != v);
        endcase
        return t;
    endfunction

    // Reset forces the FETCH decode in the same cycle so a stalled store is dropped at once.
    assign cur   = rst ? S_FETCH : state_q;
    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        addr_sel  = 1'b0;
        addr_en   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        dest      = 3'd0;
        srcA      = 3'd0;
        srcB      = 3'd0;
        opB_sel   = 1'b0;
        alu_func  = 3'd0;
        shift_op  = 2'd0;
        cc_en     = 1'b0;

        case (cur)
            S_FETCH: begin
                mem_ren = 1'b1;
                ir_en   = mem_ready;
                pc_en   = mem_ready;
                state_d = mem_ready ? S_EXECUTE : S_FETCH;
            end

            S_EXECUTE: begin
                if (op == OP_BCC) begin
                    srcA      = 3'd7;
                    dest      = 3'd7;
                    opB_sel   = 1'b1;
                    reg_write = branch_taken(cond, flags);
                    state_d   = S_FETCH;
                end else begin
                    srcA     = rs1;
                    srcB     = rs2;
                    opB_sel  = itype;
                    shift_op = itype ? 2'b00 : shf;
                    if (op == OP_LDST) begin
                        addr_en = 1'b1;
                        state_d = S_MEMORY;
                    end else begin
                        reg_write = 1'b1;
                        dest      = rd;
                        alu_func  = op;
                        cc_en     = ls_bit;
                        state_d   = S_FETCH;
                    end
                end
            end

            S_MEMORY: begin
                addr_sel = 1'b1;
                if (ls_bit) begin
                    mem_wen = 1'b1;
                    srcB    = rd;
                end else begin
                    mem_ren   = 1'b1;
                    dest      = rd;
                    wb_sel    = 1'b1;
                    reg_write = mem_ready;
                end
                state_d = mem_ready ? S_FETCH : S_MEMORY;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_stump_control_fsm.sv
// Bench for stump_control_fsm: decode table, multi-cycle corner sequences,
// a full branch-condition sweep and random traffic against a phase-level model.
module tb_stump_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] ir;
    logic [3:0]  flags;
    logic        mem_ready;
    logic [1:0]  state;
    logic        ir_en, pc_en, mem_ren, mem_wen, addr_sel, addr_en, reg_write, wb_sel;
    logic [2:0]  dest, srcA, srcB;
    logic        opB_sel;
    logic [2:0]  alu_func;
    logic [1:0]  shift_op;
    logic        cc_en;

    stump_control_fsm dut (
        .clk(clk), .rst(rst), .ir(ir), .flags(flags), .mem_ready(mem_ready),
        .state(state), .ir_en(ir_en), .pc_en(pc_en), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .addr_sel(addr_sel), .addr_en(addr_en),
        .reg_write(reg_write), .wb_sel(wb_sel), .dest(dest), .srcA(srcA),
        .srcB(srcB), .opB_sel(opB_sel), .alu_func(alu_func),
        .shift_op(shift_op), .cc_en(cc_en)
    );

    typedef struct packed {
        logic [1:0] state;
        logic       ir_en, pc_en, mem_ren, mem_wen, addr_sel, addr_en, reg_write, wb_sel;
        logic [2:0] dest, srcA, srcB;
        logic       opB_sel;
        logic [2:0] alu_func;
        logic [1:0] shift_op;
        logic       cc_en;
    } out_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  flags;
        out_t        exp;
        logic [1:0]  nxt;
    } vec_t;

    out_t dut_o;
    assign dut_o = {state, ir_en, pc_en, mem_ren, mem_wen, addr_sel, addr_en, reg_write,
                    wb_sel, dest, srcA, srcB, opB_sel, alu_func, shift_op, cc_en};

    int   checks = 0;
    int   passed = 0;
    int   ph = 0;
    vec_t tbl[$];

    // Conditions come in complementary pairs; the even member is listed, odd inverts it.
    function automatic logic taken(input logic [3:0] c, input logic [3:0] f);
        logic e;
        case (c[3:1])
            3'd0: e = 1'b1;
            3'd1: e = !f[0] && !f[2];
            3'd2: e = !f[0];
            3'd3: e = !f[2];
            3'd4: e = !f[1];
            3'd5: e = !f[3];
            3'd6: e = (f[3] == f[1]);
            default: e = !f[2] && (f[3] == f[1]);
        endcase
        return e ^ c[0];
    endfunction

    // ph: 0 = fetching, 1 = executing, 2 = memory access
    function automatic out_t model(input int p, input logic [15:0] i, input logic [3:0] f,
                                   input logic mr, input logic r);
        out_t o;
        o = '0;
        if (r) p = 0;
        o.state = p[1:0];
        if (p == 0) begin
            o.mem_ren = 1'b1;
            o.ir_en   = mr;
            o.pc_en   = mr;
        end else if (p == 1) begin
            if (i[15:13] == 3'd7) begin
                o.srcA = 3'd7; o.dest = 3'd7; o.opB_sel = 1'b1;
                o.reg_write = taken(i[11:8], f);
            end else begin
                o.srcA = i[7:5]; o.srcB = i[4:2]; o.opB_sel = i[12];
                o.shift_op = i[12] ? 2'd0 : i[1:0];
                if (i[15:13] == 3'd6) o.addr_en = 1'b1;
                else begin
                    o.reg_write = 1'b1; o.dest = i[10:8];
                    o.alu_func = i[15:13]; o.cc_en = i[11];
                end
            end
        end else begin
            o.addr_sel = 1'b1;
            if (i[11]) begin
                o.mem_wen = 1'b1; o.srcB = i[10:8];
            end else begin
                o.mem_ren = 1'b1; o.dest = i[10:8]; o.wb_sel = 1'b1; o.reg_write = mr;
            end
        end
        return o;
    endfunction

    function automatic int next_ph(input int p, input logic [15:0] i, input logic mr, input logic r);
        if (r) return 0;
        if (p == 0) return mr ? 1 : 0;
        if (p == 1) return (i[15:13] == 3'd6) ? 2 : 0;
        return mr ? 0 : 2;
    endfunction

    function automatic out_t mk(input logic rw, input logic [2:0] d, input logic [2:0] a,
                                input logic [2:0] b, input logic ob, input logic [2:0] fn,
                                input logic [1:0] sh, input logic cc, input logic ae);
        out_t o;
        o = '0;
        o.state = 2'b01; o.reg_write = rw; o.dest = d; o.srcA = a; o.srcB = b;
        o.opB_sel = ob; o.alu_func = fn; o.shift_op = sh; o.cc_en = cc; o.addr_en = ae;
        return o;
    endfunction

    task automatic add(input logic [15:0] i, input logic [3:0] f, input out_t e, input logic [1:0] n);
        vec_t v;
        v.ir = i; v.flags = f; v.exp = e; v.nxt = n;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [15:0] i, input logic [3:0] f, input logic mr);
        rst = r; ir = i; flags = f; mem_ready = mr;
    endtask

    task automatic sample(input string name);
        @(negedge clk);
        chk(name, 32'(dut_o), 32'(model(ph, ir, flags, mem_ready, rst)));
    endtask

    task automatic advance();
        ph = next_ph(ph, ir, mem_ready, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name);
        sample(name);
        advance();
    endtask

    initial begin
        logic [15:0] bir;
        logic [15:0] rir;

        //      ir        flags  rw dest srcA srcB opB alu sh cc ae    next
        add(16'h1A23, 4'h0, mk(1, 3'd2, 3'd1, 3'd0, 1, 3'd0, 2'd0, 1, 0), 2'b00);
        add(16'h2396, 4'h0, mk(1, 3'd3, 3'd4, 3'd5, 0, 3'd1, 2'd2, 0, 0), 2'b00);
        add(16'hAFC5, 4'hF, mk(1, 3'd7, 3'd6, 3'd1, 0, 3'd5, 2'd1, 1, 0), 2'b00);
        add(16'h714C, 4'h0, mk(1, 3'd1, 3'd2, 3'd3, 1, 3'd3, 2'd0, 0, 0), 2'b00);
        add(16'h8000, 4'h0, mk(1, 3'd0, 3'd0, 3'd0, 0, 3'd4, 2'd0, 0, 0), 2'b00);
        add(16'hC120, 4'h0, mk(0, 3'd0, 3'd1, 3'd0, 0, 3'd0, 2'd0, 0, 1), 2'b10);
        add(16'hDB44, 4'h0, mk(0, 3'd0, 3'd2, 3'd1, 1, 3'd0, 2'd0, 0, 1), 2'b10);
        add(16'hC56B, 4'h0, mk(0, 3'd0, 3'd3, 3'd2, 0, 3'd0, 2'd3, 0, 1), 2'b10);
        add(16'hE705, 4'h4, mk(1, 3'd7, 3'd7, 3'd0, 1, 3'd0, 2'd0, 0, 0), 2'b00);
        add(16'hE705, 4'h0, mk(0, 3'd7, 3'd7, 3'd0, 1, 3'd0, 2'd0, 0, 0), 2'b00);
        add(16'hEE00, 4'hA, mk(1, 3'd7, 3'd7, 3'd0, 1, 3'd0, 2'd0, 0, 0), 2'b00);
        add(16'hEF00, 4'hA, mk(0, 3'd7, 3'd7, 3'd0, 1, 3'd0, 2'd0, 0, 0), 2'b00);

        // Power-on reset
        drive(1, 16'h0000, 4'h0, 0);
        step("reset0");
        drive(1, 16'h0000, 4'h0, 1);
        sample("reset1");
        chk("rst_state", 32'(state), 0);
        chk("rst_mem_ren", 32'(mem_ren), 1);
        chk("rst_addr_sel", 32'(addr_sel), 0);
        chk("rst_ir_en", 32'(ir_en), 1);
        advance();

        // Fetch stall then release
        for (int k = 0; k < 3; k++) begin
            drive(0, 16'h1A23, 4'h0, 0);
            sample("fstall");
            chk("fstall_ir_en", 32'(ir_en), 0);
            chk("fstall_pc_en", 32'(pc_en), 0);
            chk("fstall_state", 32'(state), 0);
            advance();
        end
        drive(0, 16'h1A23, 4'h0, 1);
        sample("frel");
        chk("frel_ir_en", 32'(ir_en), 1);
        chk("frel_pc_en", 32'(pc_en), 1);
        advance();
        drive(0, 16'h1A23, 4'h0, 0);
        sample("frel_exec");
        chk("frel_exec_state", 32'(state), 1);
        chk("frel_exec_pc_en", 32'(pc_en), 0);
        advance();

        // Decode table: fetch, execute (mem_ready low to show it is ignored), next state
        foreach (tbl[k]) begin
            drive(0, tbl[k].ir, tbl[k].flags, 1);
            step("tbl_fetch");
            drive(0, tbl[k].ir, tbl[k].flags, 0);
            sample("tbl_exec_model");
            chk($sformatf("tbl_exec_%0d", k), 32'(dut_o), 32'(tbl[k].exp));
            advance();
            drive(0, tbl[k].ir, tbl[k].flags, tbl[k].nxt == 2'b10);
            sample("tbl_next_model");
            chk($sformatf("tbl_next_%0d", k), 32'(state), 32'(tbl[k].nxt));
            advance();
        end

        // Load with two wait states
        drive(0, 16'hC120, 4'h0, 1); step("ld_fetch");
        drive(0, 16'hC120, 4'h0, 1); step("ld_exec");
        for (int k = 0; k < 2; k++) begin
            drive(0, 16'hC120, 4'h0, 0);
            sample("ld_wait");
            chk("ld_wait_state", 32'(state), 2);
            chk("ld_wait_addr_sel", 32'(addr_sel), 1);
            chk("ld_wait_mem_ren", 32'(mem_ren), 1);
            chk("ld_wait_reg_write", 32'(reg_write), 0);
            advance();
        end
        drive(0, 16'hC120, 4'h0, 1);
        sample("ld_done");
        chk("ld_done_reg_write", 32'(reg_write), 1);
        chk("ld_done_wb_sel", 32'(wb_sel), 1);
        chk("ld_done_dest", 32'(dest), 1);
        chk("ld_done_addr_sel", 32'(addr_sel), 1);
        advance();
        drive(0, 16'hC120, 4'h0, 0);
        sample("ld_after");
        chk("ld_after_state", 32'(state), 0);
        advance();

        // Store
        drive(0, 16'hDB44, 4'h0, 1); step("st_fetch");
        drive(0, 16'hDB44, 4'h0, 0);
        sample("st_exec");
        chk("st_exec_addr_en", 32'(addr_en), 1);
        advance();
        drive(0, 16'hDB44, 4'h0, 1);
        sample("st_mem");
        chk("st_mem_wen", 32'(mem_wen), 1);
        chk("st_mem_srcB", 32'(srcB), 3);
        chk("st_mem_reg_write", 32'(reg_write), 0);
        advance();

        // Reset while a store is stalled in MEMORY
        drive(0, 16'hDB44, 4'h0, 1); step("rs_fetch");
        drive(0, 16'hDB44, 4'h0, 1); step("rs_exec");
        drive(0, 16'hDB44, 4'h0, 0);
        sample("rs_stall");
        chk("rs_stall_mem_wen", 32'(mem_wen), 1);
        advance();
        for (int k = 0; k < 2; k++) begin
            drive(1, 16'hDB44, 4'h0, 0);
            sample("rs_rst");
            chk("rs_rst_mem_wen", 32'(mem_wen), 0);
            chk("rs_rst_mem_ren", 32'(mem_ren), 1);
            advance();
        end
        drive(0, 16'hDB44, 4'h0, 0);
        sample("rs_after");
        chk("rs_after_state", 32'(state), 0);
        chk("rs_after_mem_wen", 32'(mem_wen), 0);
        chk("rs_after_mem_ren", 32'(mem_ren), 1);
        chk("rs_after_addr_sel", 32'(addr_sel), 0);
        advance();

        // All 16 conditions against all 16 flag patterns
        for (int c = 0; c < 16; c++) begin
            for (int fv = 0; fv < 16; fv++) begin
                bir = {3'b111, 1'b0, c[3:0], 8'($urandom)};
                drive(0, bir, fv[3:0], 1);
                step("bcc_fetch");
                drive(0, bir, fv[3:0], 1'($urandom));
                sample("bcc_exec");
                chk($sformatf("bcc_c%0d_f%0h", c, fv), 32'(reg_write), 32'(taken(c[3:0], fv[3:0])));
                advance();
            end
        end

        // Random traffic; the instruction only changes while fetching
        rir = 16'h0000;
        for (int n = 0; n < 400; n++) begin
            if (ph == 0) rir = 16'($urandom);
            drive(($urandom % 32) == 0, rir, 4'($urandom), ($urandom % 4) != 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stump_control_fsm.md
# stump_control_fsm

Instruction-sequencing controller for the Stump 16-bit processor. It steps the core through FETCH, EXECUTE and MEMORY states and decodes the instruction register into datapath controls: register-file ports, ALU function, operand-B and memory-address 16-bit mux selects, and memory strobes. It also evaluates branch conditions against the NZVC flags. It sits between the instruction register/flags and the datapath, and stalls on a memory-ready handshake.

## Interface
- No parameters. Encodings are fixed by the Stump ISA.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- ir  input  16  current instruction register contents.
- flags  input  4  {N,Z,V,C} from the condition-code register.
- mem_ready  input  1  memory access completes this cycle.
- state  output  2  FETCH=00, EXECUTE=01, MEMORY=10.
- ir_en  output  1  load IR from memory read data.
- pc_en  output  1  increment PC (R7).
- mem_ren / mem_wen  output  1 each  memory read / write strobe.
- addr_sel  output  1  memory-address mux select: 0=PC, 1=address register.
- addr_en  output  1  load address register from ALU result.
- reg_write  output  1  register-file write enable.
- wb_sel  output  1  write-back mux select: 0=ALU, 1=memory data.
- dest, srcA, srcB  output  3 each  register-file write and read addresses.
- opB_sel  output  1  operand-B mux select: 0=register, 1=sign-extended immediate.
- alu_func  output  3  ALU operation code.
- shift_op  output  2  operand-A shift code.
- cc_en  output  1  flag register update enable.

## Operation
- IR fields: op=ir[15:13], type=ir[12], S/LS=ir[11], Rd=ir[10:8], Rs1=ir[7:5], Rs2=ir[4:2], shift=ir[1:0], cond=ir[11:8].
- Opcodes: 000–101 are ALU ops (ADD, ADC, SUB, SBC, AND, OR), 110 is LD/ST (ir[11]=1 means store), 111 is Bcc.
- Only the state register is sequential. All other outputs are combinational from state, ir, flags and mem_ready.
- Any output not listed for a state is 0.
- **FETCH**
  - mem_ren=1, addr_sel=0.
  - ir_en=pc_en=mem_ready.
  - Next state: EXECUTE if mem_ready, otherwise stay in FETCH.
- **EXECUTE, ALU op**
  - reg_write=1, dest=Rd, srcA=Rs1, srcB=Rs2.
  - opB_sel=type, alu_func=op.
  - shift_op=shift when type=0, otherwise 00.
  - cc_en=ir[11].
  - Next state: FETCH.
- **EXECUTE, LD/ST**
  - srcA=Rs1, srcB=Rs2, opB_sel=type, alu_func=000.
  - shift_op rule as for ALU ops.
  - addr_en=1, cc_en=0, reg_write=0.
  - Next state: MEMORY.
- **EXECUTE, Bcc**
  - srcA=3'd7, dest=3'd7, opB_sel=1, alu_func=000, cc_en=0.
  - reg_write=taken.
  - Next state: FETCH.
  - Condition table for cond 0–15, in order:
    - 0 AL: 1
    - 1 NV: 0
    - 2 HI: !C&!Z
    - 3 LS: C|Z
    - 4 CC: !C
    - 5 CS: C
    - 6 NE: !Z
    - 7 EQ: Z
    - 8 VC: !V
    - 9 VS: V
    - 10 PL: !N
    - 11 MI: N
    - 12 GE: N==V
    - 13 LT: N!=V
    - 14 GT: !Z&(N==V)
    - 15 LE: Z|(N!=V)
- **MEMORY**
  - addr_sel=1.
  - Load: mem_ren=1, dest=Rd, wb_sel=1, reg_write=mem_ready.
  - Store: mem_wen=1, srcB=Rd (store data).
  - Next state: FETCH if mem_ready, otherwise stay in MEMORY.
- Encoding 11 is illegal. Outputs decode as all-zero, and the next state is FETCH.
- Rd=7 on an ALU op or load is legal: the write to PC is honoured.

## Timing
- Reset:
  - rst high at an edge sets state=FETCH, from any state including a stalled MEMORY.
  - During and after the reset cycle, outputs show the FETCH decode: mem_ren=1, addr_sel=0; ir_en and pc_en follow mem_ready.
  - Pending stores and loads are abandoned: no reg_write, no mem_wen.
- Instruction latency, zero-wait memory:
  - ALU op and Bcc: 2 cycles (FETCH, EXECUTE).
  - LD/ST: 3 cycles (FETCH, EXECUTE, MEMORY).
- Each cycle with mem_ready=0 in FETCH or MEMORY adds one cycle. All strobes, selects and addresses are held stable throughout the stall.
- mem_ready is ignored in EXECUTE.
- pc_en is asserted in exactly one cycle per fetch. Any reg_write to R7 occurs in EXECUTE or MEMORY, never in the same cycle as pc_en.
- flags are sampled combinationally in EXECUTE only.

## Test plan
- **Reset:**
  - Stimulus: rst=1 for 2 cycles while in MEMORY with a store and mem_ready=0.
  - Required: state=00, mem_wen=0, mem_ren=1, addr_sel=0 on the next cycle.
- **ADD immediate:**
  - Stimulus: ir=16'h1A23 (ADD, type=1, S=1, Rd=2, Rs1=1).
  - Required in EXECUTE: reg_write=1, dest=2, srcA=1, opB_sel=1, alu_func=000, shift_op=00, cc_en=1. Next state 00.
- **Load with wait states:**
  - Stimulus: ir=16'hC120 (LD R1 via R1, register form); mem_ready low for 2 MEMORY cycles.
  - Required: MEMORY held 3 cycles with addr_sel=1, mem_ren=1; reg_write=1, wb_sel=1, dest=1 only in the third.
- **Store:**
  - Stimulus: ir=16'hDB44.
  - Required: EXECUTE asserts addr_en=1; MEMORY asserts mem_wen=1, srcB=3, reg_write=0.
- **Branch EQ:**
  - Stimulus: ir=16'hE705 with flags=0100, then with flags=0000.
  - Required: reg_write=1, dest=7 in the first case; reg_write=0 in the second.
  - Also sweep all 16 conditions × 16 flag patterns against the condition table.
- **Fetch stall:**
  - Stimulus: mem_ready=0 for 3 cycles in FETCH.
  - Required: ir_en=pc_en=0 throughout; both pulse for exactly 1 cycle when mem_ready rises, then state=01.
